// File: rtl/hdmi_frame_capture.sv
// Video-input writer: registers a 640x480 parallel stream and writes active pixels as RGB444
// into the frame buffer, with geometry checks. Optional debug counters: HDMI_CAP_DEBUG_EN.
module hdmi_frame_capture #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned ADDR_W   = 19
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [23:0]       In_pData,
   input  logic              In_pVSync,
   input  logic              In_pHSync,
   input  logic              In_pVDE,
   input  logic              Cap_En,
   output logic              Mem_Write,
   output logic [ADDR_W-1:0] Mem_Write_Add,
   output logic [11:0]       Mem_Write_Data,
   output logic              FraimSync,
   output logic              Frame_Done,
   output logic              Line_Err,
   output logic              Frame_Err,
   output logic [15:0]       Deb_Line_Count,
   output logic [15:0]       Deb_Pix_Count
);

   localparam int unsigned Total = H_ACTIVE * V_ACTIVE;
   localparam int unsigned CntW  = ADDR_W + 1;
   localparam int unsigned PixW  = $clog2(H_ACTIVE + 2);
   localparam int unsigned LineW = $clog2(V_ACTIVE + 2);

   localparam logic [CntW-1:0]  TotalC  = CntW'(Total);
   localparam logic [PixW-1:0]  HActC   = PixW'(H_ACTIVE);
   localparam logic [PixW-1:0]  PixMax  = '1;
   localparam logic [LineW-1:0] VActC   = LineW'(V_ACTIVE);
   localparam logic [LineW-1:0] LineMax = '1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StVblank = 2'd1;
   localparam logic [1:0] StLine   = 2'd2;
   localparam logic [1:0] StHblank = 2'd3;

   // Input stage; only the RGB444 nibbles of the pixel are kept.
   logic [11:0] data_s1_q, data_s1_d;
   logic        vs_s1_q, vs_s1_d;
   logic        hs_s1_q, hs_s1_d;
   logic        vde_s1_q, vde_s1_d;
   logic        cap_s1_q, cap_s1_d;
   logic        vs_s2_q, vs_s2_d;
   logic        vde_s2_q, vde_s2_d;

   logic             unused_pix_lsbs;
   assign unused_pix_lsbs = ^{In_pData[19:16], In_pData[11:8], In_pData[3:0]};

   logic [1:0]        state_q, state_d;
   logic [CntW-1:0]   addr_q, addr_d;
   logic [LineW-1:0]  line_q, line_d;
   logic [PixW-1:0]   pix_q, pix_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] wadd_q, wadd_d;
   logic [11:0]       wdata_q, wdata_d;
   logic              fsync_q, fsync_d;
   logic              done_q, done_d;
   logic              line_err_q, line_err_d;
   logic              frame_err_q, frame_err_d;

   logic frame_start, line_end, vde_rise, write_req, line_set, frame_set;
   logic [1:0] fs_next;

   always_comb begin
      data_s1_d = {In_pData[23:20], In_pData[15:12], In_pData[7:4]};
      vs_s1_d   = In_pVSync;
      hs_s1_d   = In_pHSync;
      vde_s1_d  = In_pVDE;
      cap_s1_d  = Cap_En;
      vs_s2_d   = vs_s1_q;
      vde_s2_d  = vde_s1_q;
   end

   always_comb begin
      frame_start = vs_s2_q & ~vs_s1_q;
      line_end    = vde_s2_q & ~vde_s1_q;
      vde_rise    = ~vde_s2_q & vde_s1_q;
      fs_next     = cap_s1_q ? StVblank : StIdle;

      state_d   = state_q;
      addr_d    = addr_q;
      line_d    = line_q;
      pix_d     = pix_q;
      we_d      = 1'b0;
      wadd_d    = wadd_q;
      wdata_d   = wdata_q;
      fsync_d   = fsync_q;
      done_d    = 1'b0;
      line_set  = 1'b0;
      frame_set = 1'b0;

      // The first pixel of a line arrives while still in a blanking state.
      write_req = ~frame_start & vde_s1_q &
                  ((state_q == StLine) |
                   (((state_q == StVblank) | (state_q == StHblank)) & vde_rise));

      if (write_req) begin
         if (addr_q < TotalC) begin
            we_d    = 1'b1;
            wadd_d  = addr_q[ADDR_W-1:0];
            wdata_d = data_s1_q;
            addr_d  = addr_q + 1'b1;
         end else begin
            frame_set = 1'b1;
         end
      end

      if ((state_q != StIdle) && !frame_start) begin
         if (vde_rise) begin
            pix_d = PixW'(1);
         end else if ((state_q == StLine) && vde_s1_q && (pix_q != PixMax)) begin
            pix_d = pix_q + 1'b1;
         end
         if (vde_rise && !hs_s1_q) begin
            line_set = 1'b1;
         end
      end

      case (state_q)
         StIdle: begin
            if (frame_start && cap_s1_q) begin
               state_d = StVblank;
            end
         end
         StVblank: begin
            if (frame_start) begin
               frame_set = 1'b1;
               state_d   = fs_next;
            end else if (vde_rise) begin
               state_d = StLine;
            end
         end
         StLine: begin
            if (frame_start) begin
               frame_set = 1'b1;
               state_d   = fs_next;
            end else if (line_end) begin
               state_d = StHblank;
               if (pix_q != HActC) begin
                  line_set = 1'b1;
               end
               if (line_q != LineMax) begin
                  line_d = line_q + 1'b1;
               end
            end
         end
         StHblank: begin
            if (frame_start) begin
               if (line_q != VActC) begin
                  frame_set = 1'b1;
               end else begin
                  done_d  = 1'b1;
                  fsync_d = ~fsync_q;
               end
               state_d = fs_next;
            end else if (vde_rise) begin
               state_d = StLine;
            end
         end
         default: state_d = StIdle;
      endcase

      if (frame_start) begin
         addr_d = '0;
         line_d = '0;
      end

      // A frame start clears the sticky flags unless it raises a new error itself.
      line_err_d  = line_set | (line_err_q & ~frame_start);
      frame_err_d = frame_set | (frame_err_q & ~frame_start);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_s1_q   <= '0;
         vs_s1_q     <= 1'b0;
         hs_s1_q     <= 1'b0;
         vde_s1_q    <= 1'b0;
         cap_s1_q    <= 1'b0;
         vs_s2_q     <= 1'b0;
         vde_s2_q    <= 1'b0;
         state_q     <= StIdle;
         addr_q      <= '0;
         line_q      <= '0;
         pix_q       <= '0;
         we_q        <= 1'b0;
         wadd_q      <= '0;
         wdata_q     <= '0;
         fsync_q     <= 1'b0;
         done_q      <= 1'b0;
         line_err_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         data_s1_q   <= data_s1_d;
         vs_s1_q     <= vs_s1_d;
         hs_s1_q     <= hs_s1_d;
         vde_s1_q    <= vde_s1_d;
         cap_s1_q    <= cap_s1_d;
         vs_s2_q     <= vs_s2_d;
         vde_s2_q    <= vde_s2_d;
         state_q     <= state_d;
         addr_q      <= addr_d;
         line_q      <= line_d;
         pix_q       <= pix_d;
         we_q        <= we_d;
         wadd_q      <= wadd_d;
         wdata_q     <= wdata_d;
         fsync_q     <= fsync_d;
         done_q      <= done_d;
         line_err_q  <= line_err_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign Mem_Write      = we_q;
   assign Mem_Write_Add  = wadd_q;
   assign Mem_Write_Data = wdata_q;
   assign FraimSync      = fsync_q;
   assign Frame_Done     = done_q;
   assign Line_Err       = line_err_q;
   assign Frame_Err      = frame_err_q;

`ifdef HDMI_CAP_DEBUG_EN
   logic [LineW-1:0] deb_line_q, deb_line_d;
   logic [PixW-1:0]  deb_pix_q, deb_pix_d;

   always_comb begin
      deb_line_d = line_d;
      deb_pix_d  = pix_d;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         deb_line_q <= '0;
         deb_pix_q  <= '0;
      end else begin
         deb_line_q <= deb_line_d;
         deb_pix_q  <= deb_pix_d;
      end
   end

   assign Deb_Line_Count = 16'(deb_line_q);
   assign Deb_Pix_Count  = 16'(deb_pix_q);
`else
   assign Deb_Line_Count = 16'h0000;
   assign Deb_Pix_Count  = 16'h0000;
`endif

endmodule

// File: tb/tb_hdmi_frame_capture.sv
// Directed-random bench for hdmi_frame_capture on a reduced 8x4 geometry, checked against a
// frame-level model of which pixels land where and which flags each frame should raise.
module tb_hdmi_frame_capture;

   localparam int H     = 8;
   localparam int V     = 4;
   localparam int AW    = 5;
   localparam int TOTAL = H * V;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [23:0]   pdata = '0;
   logic          vs = 1'b1;
   logic          hs = 1'b1;
   logic          vde = 1'b0;
   logic          cap = 1'b0;
   logic          Mem_Write;
   logic [AW-1:0] Mem_Write_Add;
   logic [11:0]   Mem_Write_Data;
   logic          FraimSync, Frame_Done, Line_Err, Frame_Err;
   logic [15:0]   Deb_Line_Count, Deb_Pix_Count;

   hdmi_frame_capture #(
      .H_ACTIVE(H),
      .V_ACTIVE(V),
      .ADDR_W  (AW)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .In_pData      (pdata),
      .In_pVSync     (vs),
      .In_pHSync     (hs),
      .In_pVDE       (vde),
      .Cap_En        (cap),
      .Mem_Write     (Mem_Write),
      .Mem_Write_Add (Mem_Write_Add),
      .Mem_Write_Data(Mem_Write_Data),
      .FraimSync     (FraimSync),
      .Frame_Done    (Frame_Done),
      .Line_Err      (Line_Err),
      .Frame_Err     (Frame_Err),
      .Deb_Line_Count(Deb_Line_Count),
      .Deb_Pix_Count (Deb_Pix_Count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int addr;
      int data;
      int cy;
   } wr_t;

   wr_t act_q[$];
   wr_t exp_q[$];
   int  done_cnt = 0;

   always @(negedge clk) begin
      if (Mem_Write === 1'b1) act_q.push_back('{int'(Mem_Write_Add), int'(Mem_Write_Data), cyc});
      if (Frame_Done === 1'b1) done_cnt <= done_cnt + 1;
   end

   // Frame-level reference model
   bit          cap_cur = 0;
   bit          line_err_m = 0;
   bit          frame_err_m = 0;
   bit          fsync_m = 0;
   int          addr_m = 0;
   int          lines_m = 0;
   int          done_m = 0;
   int          checks = 0;
   int          errors = 0;
   bit          use_first = 0;
   logic [23:0] first_px = 24'hA5C3F0;

   function automatic logic [11:0] rgb444(input logic [23:0] p);
      return {p[23:20], p[15:12], p[7:4]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic model_fs(input bit c, input bit aborted);
      bit ferr;
      ferr = 0;
      if (cap_cur) begin
         if (aborted || lines_m != V) ferr = 1;
         else begin
            done_m++;
            fsync_m = ~fsync_m;
         end
      end
      line_err_m  = 0;
      frame_err_m = ferr;
      cap_cur     = c;
      addr_m      = 0;
      lines_m     = 0;
   endtask

   task automatic model_pixel(input logic [23:0] p);
      if (cap_cur) begin
         if (addr_m < TOTAL) begin
            exp_q.push_back('{addr_m, int'(rgb444(p)), cyc + 2});
            addr_m++;
         end else begin
            frame_err_m = 1;
         end
      end
   endtask

   task automatic model_line_end(input int len, input bit hs_bad);
      if (cap_cur) begin
         if (len != H || hs_bad) line_err_m = 1;
         lines_m++;
      end
   endtask

   task automatic step(input bit v, input bit h, input bit d, input logic [23:0] px);
      @(negedge clk);
      vs    = v;
      hs    = h;
      vde   = d;
      pdata = px;
   endtask

   task automatic idle(input int n);
      repeat (n) step(vs, 1'b1, 1'b0, 24'h0);
   endtask

   task automatic check_flags(input string tag);
      chk({tag, "_line_err"}, Line_Err, line_err_m);
      chk({tag, "_frame_err"}, Frame_Err, frame_err_m);
      chk({tag, "_fraimsync"}, FraimSync, fsync_m);
      chk({tag, "_done_cnt"}, done_cnt, done_m);
`ifdef HDMI_CAP_DEBUG_EN
      chk({tag, "_deb_line"}, Deb_Line_Count, lines_m);
`else
      chk({tag, "_deb_line"}, Deb_Line_Count, 0);
      chk({tag, "_deb_pix"}, Deb_Pix_Count, 0);
`endif
   endtask

   task automatic check_writes(input string tag);
      int n;
      chk({tag, "_nwrites"}, act_q.size(), exp_q.size());
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_addr%0d", tag, i), act_q[i].addr, exp_q[i].addr);
         chk($sformatf("%s_data%0d", tag, i), act_q[i].data, exp_q[i].data);
         chk($sformatf("%s_cycle%0d", tag, i), act_q[i].cy, exp_q[i].cy);
      end
      act_q.delete();
      exp_q.delete();
   endtask

   // One frame: VSync pulse (the frame start), blanking, then nl lines of H pixels unless a
   // line index selects a short line, a bad HSync qualifier, or a mid-line abort.
   task automatic drive_frame(input string tag, input int nl, input int short_l,
                              input int abort_l, input int hsbad_l, input bit c);
      bit          ab;
      int          len;
      logic [23:0] px;
      ab = 0;
      if (vs) begin
         step(1'b0, 1'b1, 1'b0, 24'h0);
         cap = c;
         model_fs(c, 1'b0);
      end else begin
         step(1'b0, 1'b1, 1'b0, 24'h0);
         cap = c;
      end
      step(1'b0, 1'b1, 1'b0, 24'h0);
      repeat (3) step(1'b1, 1'b1, 1'b0, 24'h0);
      check_flags({tag, "_postfs"});
      for (int l = 0; l < nl && !ab; l++) begin
         step(1'b1, 1'b0, 1'b0, 24'h0);
         step(1'b1, 1'b0, 1'b0, 24'h0);
         step(1'b1, 1'b1, 1'b0, 24'h0);
         len = (l == short_l) ? H - 1 : H;
         if (l == abort_l) len = 3;
         for (int p = 0; p < len; p++) begin
            px = (use_first && l == 0 && p == 0) ? first_px : 24'($urandom());
            step(1'b1, !(l == hsbad_l && p == 0), 1'b1, px);
            model_pixel(px);
         end
         if (l == abort_l) begin
            step(1'b0, 1'b1, 1'b1, 24'($urandom()));
            model_fs(cap, 1'b1);
            step(1'b0, 1'b1, 1'b0, 24'h0);
            ab = 1;
         end else begin
            step(1'b1, 1'b1, 1'b0, 24'h0);
            step(1'b1, 1'b1, 1'b0, 24'h0);
            model_line_end(len, l == hsbad_l);
         end
      end
      idle(3);
      check_flags({tag, "_eof"});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [23:0] px;
      repeat (3) @(negedge clk);
      chk("rst_mem_write", Mem_Write, 0);
      chk("rst_mem_add", Mem_Write_Add, 0);
      chk("rst_mem_data", Mem_Write_Data, 0);
      check_flags("rst");
      rstn = 1'b1;
      idle(4);

      use_first = 1;
      drive_frame("f1", V, -1, -1, -1, 1'b1);
      use_first = 0;
      chk("f1_count", act_q.size(), TOTAL);
      if (act_q.size() > 0) begin
         chk("f1_first_addr", act_q[0].addr, 0);
         chk("f1_first_data", act_q[0].data, 12'hACF);
      end
      check_writes("f1");
      drive_frame("f2", V, -1, -1, -1, 1'b1);
      check_writes("f2");
      drive_frame("f3_short", V, 2, -1, -1, 1'b1);
      check_writes("f3");
      drive_frame("f4_abort", V, -1, 1, -1, 1'b1);
      check_writes("f4");
      drive_frame("f5_extra", V + 1, -1, -1, -1, 1'b1);
      check_writes("f5");
      drive_frame("f6_hsbad", V, -1, -1, 0, 1'b1);
      check_writes("f6");
      drive_frame("f7_nocap", V, -1, -1, -1, 1'b0);
      check_writes("f7");
      drive_frame("f8", V, -1, -1, -1, 1'b1);
      check_writes("f8");

      // Partial frame interrupted by an asynchronous reset in the middle of a line
      step(1'b0, 1'b1, 1'b0, 24'h0);
      cap = 1'b1;
      model_fs(1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 24'h0);
      repeat (3) step(1'b1, 1'b1, 1'b0, 24'h0);
      check_flags("f9_postfs");
      step(1'b1, 1'b0, 1'b0, 24'h0);
      step(1'b1, 1'b1, 1'b0, 24'h0);
      for (int p = 0; p < 3; p++) begin
         px = 24'($urandom());
         step(1'b1, 1'b1, 1'b1, px);
         model_pixel(px);
      end
      #2 rstn = 1'b0;
      #1;
      act_q.delete();
      exp_q.delete();
      cap_cur     = 0;
      line_err_m  = 0;
      frame_err_m = 0;
      fsync_m     = 0;
      addr_m      = 0;
      lines_m     = 0;
      chk("midrst_mem_write", Mem_Write, 0);
      chk("midrst_mem_add", Mem_Write_Add, 0);
      chk("midrst_mem_data", Mem_Write_Data, 0);
      chk("midrst_frame_done", Frame_Done, 0);
      check_flags("midrst");
      step(1'b1, 1'b1, 1'b1, 24'($urandom()));
      step(1'b1, 1'b1, 1'b0, 24'h0);
      rstn = 1'b1;
      idle(4);
      check_writes("f9");

      drive_frame("f10", V, -1, -1, -1, 1'b1);
      check_writes("f10");
      drive_frame("f11", V, -1, -1, -1, 1'b1);
      check_writes("f11");
      drive_frame("f12_close", 0, -1, -1, -1, 1'b0);
      check_writes("f12");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
